sipo_receiver: RTL and testbench

Serial-in/parallel-out receiver forming the far end of the 40-bit serial link driven by the team's parallel-to-serial transmitter. It samples the MSB-first bit stream qualified by the transmitter's ready strobe and assembles complete words. Each completed word is presented on a held parallel output with a valid/acknowledge handshake toward the downstream consumer. It detects aborted frames and consumer overruns.

---
 rtl/sipo_receiver.sv | 152 +++++++++++++++
 tb/tb_sipo_receiver.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sipo_receiver.sv
// Serial-in/parallel-out receiver: MSB-first frames qualified by InReady, valid/ack output handshake.
// Optional build macro SIPO_PARITY_EN appends an even-parity bit to each frame and adds ParityErr.
module sipo_receiver #(
  parameter int WIDTH = 40
) (
  input  logic             Sclk,
  input  logic             Clear_n,
  input  logic             InReady,
  input  logic             Serial_in,
  input  logic             s2p_ack,
  output logic [WIDTH-1:0] Parallel_out,
  output logic             DataValid,
  output logic             Busy,
  output logic             FrameErr,
`ifdef SIPO_PARITY_EN
  output logic             ParityErr,
`endif
  output logic             Overrun
);

`ifdef SIPO_PARITY_EN
  localparam int FRAME_LEN = WIDTH + 1;
`else
  localparam int FRAME_LEN = WIDTH;
`endif
  localparam int CNT_W = $clog2(WIDTH + 2);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_LEN - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] bitCount_q, bitCount_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [WIDTH-1:0] parOut_q, parOut_d;
  logic             valid_q, valid_d;
  logic             frameErr_q, frameErr_d;
  logic             overrun_q, overrun_d;
`ifdef SIPO_PARITY_EN
  logic             parityErr_q, parityErr_d;
`endif

  logic             wordDone;
  logic             wordOk;
  logic [WIDTH-1:0] word;

  always_ff @(posedge Sclk) begin
    if (!Clear_n) begin
      state_q     <= IDLE;
      bitCount_q  <= '0;
      shift_q     <= '0;
      parOut_q    <= '0;
      valid_q     <= 1'b0;
      frameErr_q  <= 1'b0;
      overrun_q   <= 1'b0;
`ifdef SIPO_PARITY_EN
      parityErr_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      bitCount_q  <= bitCount_d;
      shift_q     <= shift_d;
      parOut_q    <= parOut_d;
      valid_q     <= valid_d;
      frameErr_q  <= frameErr_d;
      overrun_q   <= overrun_d;
`ifdef SIPO_PARITY_EN
      parityErr_q <= parityErr_d;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    bitCount_d  = bitCount_q;
    shift_d     = shift_q;
    parOut_d    = parOut_q;
    valid_d     = valid_q;
    frameErr_d  = frameErr_q;
    overrun_d   = overrun_q;
    wordDone    = 1'b0;
`ifdef SIPO_PARITY_EN
    parityErr_d = parityErr_q;
    // The last frame bit is parity; the data word is already fully shifted in.
    word        = shift_q;
    wordOk      = ((^shift_q) == Serial_in);
`else
    word        = {shift_q[WIDTH-2:0], Serial_in};
    wordOk      = 1'b1;
`endif

    case (state_q)
      IDLE: begin
        bitCount_d = '0;
        if (InReady) begin
          shift_d    = {{(WIDTH-1){1'b0}}, Serial_in};
          bitCount_d = CNT_W'(1);
          state_d    = SHIFT;
        end
      end
      SHIFT: begin
        if (InReady) begin
          if (bitCount_q == LAST_IDX) begin
            wordDone   = 1'b1;
            shift_d    = '0;
            bitCount_d = '0;
            state_d    = IDLE;
          end else begin
            shift_d    = {shift_q[WIDTH-2:0], Serial_in};
            bitCount_d = bitCount_q + 1'b1;
          end
        end else begin
          frameErr_d = 1'b1;
          shift_d    = '0;
          bitCount_d = '0;
          state_d    = IDLE;
        end
      end
      default: begin
        state_d    = IDLE;
        bitCount_d = '0;
      end
    endcase

    // A good word is taken if the holding register is free or being acked this edge.
    if (wordDone && wordOk) begin
      if (!valid_q || s2p_ack) begin
        parOut_d = word;
        valid_d  = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else begin
`ifdef SIPO_PARITY_EN
      if (wordDone) begin
        frameErr_d  = 1'b1;
        parityErr_d = 1'b1;
      end
`endif
      if (s2p_ack) valid_d = 1'b0;
    end
  end

  assign Parallel_out = parOut_q;
  assign DataValid    = valid_q;
  assign Busy         = (state_q == SHIFT);
  assign FrameErr     = frameErr_q;
  assign Overrun      = overrun_q;
`ifdef SIPO_PARITY_EN
  assign ParityErr    = parityErr_q;
`endif

endmodule

// File: tb/tb_sipo_receiver.sv
// Self-checking bench for sipo_receiver: directed scenarios plus randomized frames against a bit-queue model.
module tb_sipo_receiver;
  localparam int WIDTH = 40;
`ifdef SIPO_PARITY_EN
  localparam int FRAME = WIDTH + 1;
`else
  localparam int FRAME = WIDTH;
`endif

  logic             Sclk = 1'b0;
  logic             Clear_n = 1'b0;
  logic             InReady = 1'b0;
  logic             Serial_in = 1'b0;
  logic             s2p_ack = 1'b0;
  logic [WIDTH-1:0] Parallel_out;
  logic             DataValid, Busy, FrameErr, Overrun;
  logic             perrObs;

  int nChecks = 0;
  int nPass   = 0;

  logic [WIDTH-1:0] expOut;
  logic             expValid, expFerr, expOvr, expPerr;
  bit               bitQ[$];

  sipo_receiver #(.WIDTH(WIDTH)) dut (
    .Sclk        (Sclk),
    .Clear_n     (Clear_n),
    .InReady     (InReady),
    .Serial_in   (Serial_in),
    .s2p_ack     (s2p_ack),
    .Parallel_out(Parallel_out),
    .DataValid   (DataValid),
    .Busy        (Busy),
    .FrameErr    (FrameErr),
`ifdef SIPO_PARITY_EN
    .ParityErr   (perrObs),
`endif
    .Overrun     (Overrun)
  );

`ifndef SIPO_PARITY_EN
  assign perrObs = 1'b0;
`endif

  always #5 Sclk = ~Sclk;

  wire [WIDTH+4:0] obsVec = {Parallel_out, DataValid, Busy, FrameErr, Overrun, perrObs};

  function automatic logic [WIDTH+4:0] expVec();
    return {expOut, expValid, (bitQ.size() > 0), expFerr, expOvr, expPerr};
  endfunction

  task automatic modelReset();
    expOut = '0; expValid = 0; expFerr = 0; expOvr = 0; expPerr = 0;
    bitQ.delete();
  endtask

  // One clock: drive on the falling edge, update the model at the rising edge, settle 1 time unit.
  task automatic step(input bit rdy, input bit sin, input bit ack);
    logic [WIDTH-1:0] w;
    bit done, parOk;
    @(negedge Sclk);
    Clear_n = 1'b1; InReady = rdy; Serial_in = sin; s2p_ack = ack;
    @(posedge Sclk);
    done = 0; parOk = 1;
    if (rdy) begin
      bitQ.push_back(sin);
      if (bitQ.size() == FRAME) done = 1;
    end else if (bitQ.size() != 0) begin
      expFerr = 1;
      bitQ.delete();
    end
    if (done) begin
      w = '0;
      for (int i = 0; i < WIDTH; i++) w = {w[WIDTH-2:0], bitQ[i]};
`ifdef SIPO_PARITY_EN
      parOk = ($countones({w, bitQ[WIDTH]}) % 2) == 0;
`endif
      bitQ.delete();
      if (!parOk) begin
        expFerr = 1; expPerr = 1;
        if (ack) expValid = 0;
      end else if (!expValid || ack) begin
        expOut = w; expValid = 1;
      end else begin
        expOvr = 1;
      end
    end else if (ack) begin
      expValid = 0;
    end
    #1;
  endtask

  task automatic doReset(input bit rdy);
    @(negedge Sclk);
    Clear_n = 1'b0; InReady = rdy; Serial_in = $urandom_range(0, 1); s2p_ack = $urandom_range(0, 1);
    @(posedge Sclk);
    modelReset();
    #1;
  endtask

  // Sends the first nbits MSB-first bits of w; a full word also gets its parity bit when enabled.
  task automatic sendWord(input logic [WIDTH-1:0] w, input int nbits, input bit ackLast, input bit badPar);
    for (int i = 0; i < nbits; i++)
      step(1'b1, w[WIDTH-1-i], ackLast && (i == nbits - 1) && (FRAME == WIDTH));
`ifdef SIPO_PARITY_EN
    if (nbits == WIDTH) step(1'b1, (^w) ^ badPar, ackLast);
`endif
  endtask

  function automatic logic [WIDTH-1:0] randWord();
    return {8'($urandom), 32'($urandom)};
  endfunction

  task automatic test_reset();
    logic [WIDTH-1:0] w;
    doReset(1'b0);
    nChecks++;
    if (obsVec !== '0) $display("[TB] FAIL reset_initial: got %h want 0", obsVec);
    else nPass++;
    w = randWord();
    sendWord(w, 17, 1'b0, 1'b0);
    doReset(1'b1);
    nChecks++;
    if (obsVec !== '0) $display("[TB] FAIL reset_midframe: got %h want 0", obsVec);
    else nPass++;
    step(1'b0, 1'b0, 1'b0);
    w = randWord();
    sendWord(w, WIDTH, 1'b0, 1'b0);
    nChecks++;
    if (Parallel_out !== w || DataValid !== 1'b1)
      $display("[TB] FAIL reset_recover: got %h/%b want %h/1", Parallel_out, DataValid, w);
    else nPass++;
  endtask

  task automatic test_single();
    logic [WIDTH-1:0] w;
    w = 40'hA5_0F3C_96E1;
    doReset(1'b0);
    sendWord(w, WIDTH - 1, 1'b0, 1'b0);
    nChecks++;
    if (DataValid !== 1'b0 || Busy !== 1'b1)
      $display("[TB] FAIL single_before_last: got valid=%b busy=%b want valid=0 busy=1", DataValid, Busy);
    else nPass++;
    step(1'b1, w[0], 1'b0);
`ifdef SIPO_PARITY_EN
    step(1'b1, ^w, 1'b0);
`endif
    nChecks++;
    if (Parallel_out !== 40'hA50F3C96E1 || DataValid !== 1'b1 || Busy !== 1'b0)
      $display("[TB] FAIL single_word: got %h valid=%b busy=%b want a50f3c96e1 valid=1 busy=0",
               Parallel_out, DataValid, Busy);
    else nPass++;
    for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 1'b0);
    nChecks++;
    if (DataValid !== 1'b1 || obsVec !== expVec())
      $display("[TB] FAIL single_hold: got %h want %h", obsVec, expVec());
    else nPass++;
  endtask

  task automatic test_back_to_back();
    doReset(1'b0);
    sendWord(40'h00_0000_0001, WIDTH, 1'b0, 1'b0);
    nChecks++;
    if (Parallel_out !== 40'h1 || DataValid !== 1'b1)
      $display("[TB] FAIL b2b_first: got %h/%b want 1/1", Parallel_out, DataValid);
    else nPass++;
    sendWord(40'hFF_FFFF_FFFE, WIDTH, 1'b1, 1'b0);
    nChecks++;
    if (Parallel_out !== 40'hFFFFFFFFFE || DataValid !== 1'b1 || Overrun !== 1'b0)
      $display("[TB] FAIL b2b_second: got %h valid=%b ovr=%b want fffffffffe valid=1 ovr=0",
               Parallel_out, DataValid, Overrun);
    else nPass++;
    nChecks++;
    if (obsVec !== expVec()) $display("[TB] FAIL b2b_model: got %h want %h", obsVec, expVec());
    else nPass++;
  endtask

  task automatic test_overrun();
    logic [WIDTH-1:0] w1, w2;
    doReset(1'b0);
    w1 = randWord();
    w2 = ~w1;
    sendWord(w1, WIDTH, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    sendWord(w2, WIDTH, 1'b0, 1'b0);
    nChecks++;
    if (Parallel_out !== w1 || Overrun !== 1'b1 || DataValid !== 1'b1)
      $display("[TB] FAIL overrun: got %h ovr=%b valid=%b want %h ovr=1 valid=1",
               Parallel_out, Overrun, DataValid, w1);
    else nPass++;
    step(1'b0, 1'b0, 1'b1);
    nChecks++;
    if (DataValid !== 1'b0 || Overrun !== 1'b1)
      $display("[TB] FAIL overrun_ack: got valid=%b ovr=%b want valid=0 ovr=1", DataValid, Overrun);
    else nPass++;
  endtask

  task automatic test_abort();
    logic [WIDTH-1:0] w;
    doReset(1'b0);
    w = randWord();
    sendWord(w, WIDTH, 1'b0, 1'b0);
    sendWord(randWord(), 25, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    nChecks++;
    if (FrameErr !== 1'b1 || DataValid !== 1'b1 || Parallel_out !== w || Busy !== 1'b0)
      $display("[TB] FAIL abort: got ferr=%b valid=%b out=%h busy=%b want ferr=1 valid=1 out=%h busy=0",
               FrameErr, DataValid, Parallel_out, Busy, w);
    else nPass++;
    step(1'b0, 1'b0, 1'b1);
    sendWord(40'h12_3456_789A, WIDTH, 1'b0, 1'b0);
    nChecks++;
    if (Parallel_out !== 40'h123456789A || DataValid !== 1'b1 || FrameErr !== 1'b1)
      $display("[TB] FAIL abort_recover: got %h valid=%b ferr=%b want 123456789a valid=1 ferr=1",
               Parallel_out, DataValid, FrameErr);
    else nPass++;
  endtask

`ifdef SIPO_PARITY_EN
  task automatic test_parity();
    doReset(1'b0);
    sendWord(40'h00_0000_0003, WIDTH, 1'b0, 1'b1);
    nChecks++;
    if (perrObs !== 1'b1 || FrameErr !== 1'b1 || DataValid !== 1'b0)
      $display("[TB] FAIL parity_bad: got perr=%b ferr=%b valid=%b want 1/1/0", perrObs, FrameErr, DataValid);
    else nPass++;
    sendWord(40'h00_0000_0003, WIDTH, 1'b0, 1'b0);
    nChecks++;
    if (DataValid !== 1'b1 || Parallel_out !== 40'h3)
      $display("[TB] FAIL parity_good: got valid=%b out=%h want 1/3", DataValid, Parallel_out);
    else nPass++;
  endtask
`endif

  task automatic test_random();
    int cut;
    doReset(1'b0);
    for (int f = 0; f < 40; f++) begin
      cut = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, WIDTH - 1)) : WIDTH;
      sendWord(randWord(), cut, 1'(($urandom_range(0, 2)) == 0), 1'(($urandom_range(0, 7)) == 0));
      if (cut != WIDTH || $urandom_range(0, 1) == 1) begin
        for (int g = 0, n = int'($urandom_range(1, 3)); g < n; g++)
          step(1'b0, 1'b0, 1'(($urandom_range(0, 3)) == 0));
      end
      nChecks++;
      if (obsVec !== expVec()) $display("[TB] FAIL random_frame%0d: got %h want %h", f, obsVec, expVec());
      else nPass++;
    end
  endtask

  initial begin
    modelReset();
    test_reset();
    test_single();
    test_back_to_back();
    test_overrun();
    test_abort();
`ifdef SIPO_PARITY_EN
    test_parity();
`endif
    test_random();
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
